// File: rtl/wfid_allocator.sv
// Wavefront slot ID allocator: grants the lowest free slot, reclaims slots on retire,
// and tracks a busy bitmap plus free-slot count.
module wfid_allocator #(
    parameter int unsigned NUM_SLOTS = 40,
    parameter int unsigned ID_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_ready,
    output logic                 alloc_valid,
    output logic [ID_WIDTH-1:0]  alloc_wfid,
    input  logic                 free_valid,
    input  logic [ID_WIDTH-1:0]  free_wfid,
    output logic                 free_err,
    output logic [ID_WIDTH-1:0]  free_count,
    output logic [NUM_SLOTS-1:0] busy_vector
);

    localparam int unsigned CNT_W = ID_WIDTH;

    logic                 handshake;
    logic                 grant_found;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic                 free_hit;
    logic                 free_legal;
    logic [NUM_SLOTS-1:0] busy_next;
    logic [CNT_W-1:0]     count_next;
    logic                 ready_next;

    assign handshake = alloc_req & alloc_ready;

    // Lowest-index free slot over the pre-edge bitmap
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!busy_vector[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
            end
        end
    end

    // A free is legal only for an in-range slot that is currently allocated
    always_comb begin
        free_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (free_wfid == ID_WIDTH'(i)) begin
                free_hit = busy_vector[i];
            end
        end
        free_legal = free_valid & free_hit;
    end

    // Next bitmap and count; the freed slot and the granted slot never coincide
    always_comb begin
        busy_next  = busy_vector;
        count_next = free_count;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (free_legal && (free_wfid == ID_WIDTH'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (handshake && (grant_idx == ID_WIDTH'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
        case ({handshake, free_legal})
            2'b10:   count_next = free_count - CNT_W'(1);
            2'b01:   count_next = free_count + CNT_W'(1);
            default: count_next = free_count;
        endcase
        ready_next = (count_next != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_vector <= '0;
            free_count  <= CNT_W'(NUM_SLOTS);
            alloc_ready <= 1'b1;
            alloc_valid <= 1'b0;
            alloc_wfid  <= '0;
            free_err    <= 1'b0;
        end else begin
            busy_vector <= busy_next;
            free_count  <= count_next;
            alloc_ready <= ready_next;
            alloc_valid <= handshake;
            free_err    <= free_valid & ~free_legal;
            if (handshake) begin
                alloc_wfid <= grant_idx;
            end
        end
    end

    // Bookkeeping invariants
    always @(posedge clk) begin
        if (rst) begin
            assert (free_count == CNT_W'(NUM_SLOTS - $countones(busy_vector)));
            assert (free_count <= CNT_W'(NUM_SLOTS));
            assert (alloc_ready == (free_count != '0));
            assert (!handshake || grant_found);
        end
    end

endmodule

// File: tb/tb_wfid_allocator.sv
// Directed self-checking bench for wfid_allocator: reset, grants, frees, full/simultaneous
// corner cases, illegal frees and mid-operation reset.
module tb_wfid_allocator;

    localparam int unsigned NUM_SLOTS = 40;
    localparam int unsigned ID_WIDTH  = 6;

    logic                 clk;
    logic                 rst;
    logic                 alloc_req;
    logic                 alloc_ready;
    logic                 alloc_valid;
    logic [ID_WIDTH-1:0]  alloc_wfid;
    logic                 free_valid;
    logic [ID_WIDTH-1:0]  free_wfid;
    logic                 free_err;
    logic [ID_WIDTH-1:0]  free_count;
    logic [NUM_SLOTS-1:0] busy_vector;

    int errors = 0;
    int checks = 0;

    wfid_allocator #(.NUM_SLOTS(NUM_SLOTS), .ID_WIDTH(ID_WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .alloc_req(alloc_req),
        .alloc_ready(alloc_ready),
        .alloc_valid(alloc_valid),
        .alloc_wfid(alloc_wfid),
        .free_valid(free_valid),
        .free_wfid(free_wfid),
        .free_err(free_err),
        .free_count(free_count),
        .busy_vector(busy_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_SLOTS-1:0] all_ones;
        all_ones   = '1;
        rst        = 1'b0;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_wfid  = '0;
        #23;
        rst = 1'b1;
        step();

        // Reset state
        check("rst_busy", 64'(busy_vector), 64'h0);
        check("rst_count", 64'(free_count), 64'd40);
        check("rst_ready", 64'(alloc_ready), 64'd1);
        check("rst_valid", 64'(alloc_valid), 64'd0);
        check("rst_wfid", 64'(alloc_wfid), 64'd0);
        check("rst_err", 64'(free_err), 64'd0);

        // Three back-to-back grants
        alloc_req = 1'b1;
        step();
        check("g0_valid", 64'(alloc_valid), 64'd1);
        check("g0_wfid", 64'(alloc_wfid), 64'd0);
        step();
        check("g1_wfid", 64'(alloc_wfid), 64'd1);
        step();
        check("g2_valid", 64'(alloc_valid), 64'd1);
        check("g2_wfid", 64'(alloc_wfid), 64'd2);
        check("g2_busy", 64'(busy_vector), 64'h7);
        check("g2_count", 64'(free_count), 64'd37);
        alloc_req = 1'b0;
        step();
        check("idle_valid", 64'(alloc_valid), 64'd0);
        check("idle_wfid_held", 64'(alloc_wfid), 64'd2);

        // Free slot 1, then it is the lowest free slot
        free_valid = 1'b1;
        free_wfid  = 6'd1;
        step();
        free_valid = 1'b0;
        check("f1_busy", 64'(busy_vector), 64'h5);
        check("f1_count", 64'(free_count), 64'd38);
        check("f1_err", 64'(free_err), 64'd0);
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        check("re_valid", 64'(alloc_valid), 64'd1);
        check("re_wfid", 64'(alloc_wfid), 64'd1);
        check("re_busy", 64'(busy_vector), 64'h7);

        // Fill the remaining 37 slots in order
        alloc_req = 1'b1;
        for (int i = 0; i < 37; i++) begin
            step();
            check($sformatf("fill_wfid_%0d", i), 64'(alloc_wfid), 64'(3 + i));
        end
        check("full_count", 64'(free_count), 64'd0);
        check("full_ready", 64'(alloc_ready), 64'd0);
        check("full_busy", 64'(busy_vector), 64'(all_ones));
        // 41st request is dropped
        step();
        check("drop_valid", 64'(alloc_valid), 64'd0);
        check("drop_count", 64'(free_count), 64'd0);
        check("drop_wfid", 64'(alloc_wfid), 64'd39);

        // Full: free 5 with a same-cycle request -> no grant, then 5 granted
        free_valid = 1'b1;
        free_wfid  = 6'd5;
        step();
        free_valid = 1'b0;
        check("sim_valid", 64'(alloc_valid), 64'd0);
        check("sim_count", 64'(free_count), 64'd1);
        check("sim_ready", 64'(alloc_ready), 64'd1);
        check("sim_busy5", 64'(busy_vector[5]), 64'd0);
        step();
        alloc_req = 1'b0;
        check("sim2_valid", 64'(alloc_valid), 64'd1);
        check("sim2_wfid", 64'(alloc_wfid), 64'd5);
        check("sim2_count", 64'(free_count), 64'd0);
        check("sim2_ready", 64'(alloc_ready), 64'd0);

        // Legal free of 7, then a double free and an out-of-range free
        free_valid = 1'b1;
        free_wfid  = 6'd7;
        step();
        check("f7_err", 64'(free_err), 64'd0);
        check("f7_count", 64'(free_count), 64'd1);
        step();
        check("f7b_err", 64'(free_err), 64'd1);
        check("f7b_count", 64'(free_count), 64'd1);
        free_wfid = 6'd45;
        step();
        free_valid = 1'b0;
        check("f45_err", 64'(free_err), 64'd1);
        check("f45_count", 64'(free_count), 64'd1);
        check("f45_busy", 64'(busy_vector), 64'(all_ones & ~(40'h1 << 7)));
        step();
        check("err_clear", 64'(free_err), 64'd0);

        // Mid-burst reset: a grant lands, then reset wipes everything at once
        alloc_req = 1'b1;
        step();
        check("pre_rst_wfid", 64'(alloc_wfid), 64'd7);
        check("pre_rst_valid", 64'(alloc_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_busy", 64'(busy_vector), 64'h0);
        check("mrst_count", 64'(free_count), 64'd40);
        check("mrst_valid", 64'(alloc_valid), 64'd0);
        check("mrst_wfid", 64'(alloc_wfid), 64'd0);
        check("mrst_ready", 64'(alloc_ready), 64'd1);
        alloc_req = 1'b0;
        #3;
        rst = 1'b1;
        step();
        check("post_rst_busy", 64'(busy_vector), 64'h0);
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        check("post_rst_wfid", 64'(alloc_wfid), 64'd0);
        check("post_rst_valid", 64'(alloc_valid), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
